// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM states, bubble encoding, PC step, reset PC default.
// FETCH_FAULT_EN adds the HALT state used after an instruction-memory error.
package fetch_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [63:0] PC_INCR          = 64'd4;
  localparam logic [31:0] NOP_INSTR        = 32'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
`ifdef FETCH_FAULT_EN
    , ST_HALT = 2'd3
`endif
  } fetch_state_e;

  // Instructions are word aligned; the low two address bits are always dropped.
  function automatic logic [63:0] align_pc(input logic [63:0] a);
    return a & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: decode-side control, instruction-memory handshake and slot outputs.
// FETCH_FAULT_EN adds imem_err and fault.
interface fetch_unit_if;
  logic        hazard;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [63:0] pc;
  logic [31:0] instruc;
  logic        valid;
`ifdef FETCH_FAULT_EN
  logic        imem_err;
  logic        fault;
`endif

  modport master (
    input  hazard, redirect, redirect_pc, imem_ack, imem_rdata,
`ifdef FETCH_FAULT_EN
    input  imem_err,
    output fault,
`endif
    output imem_req, imem_addr, pc, instruc, valid
  );

  modport slave (
    output hazard, redirect, redirect_pc, imem_ack, imem_rdata,
`ifdef FETCH_FAULT_EN
    output imem_err,
    input  fault,
`endif
    input  imem_req, imem_addr, pc, instruc, valid
  );
endinterface

// File: rtl/fetch_slot.sv
// Output holding register between fetch and decode: flush beats load beats consume.
// FETCH_FAULT_EN adds a sticky fault flag cleared only by flush.
module fetch_slot
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_consume,
  input  logic [63:0] i_load_pc,
  input  logic [31:0] i_load_instr,
`ifdef FETCH_FAULT_EN
  input  logic        i_load_fault,
  output logic        o_fault,
`endif
  output logic [63:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [63:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_flush || (i_consume && !i_load)) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_load_pc;
      r_instr <= i_load_instr;
      r_valid <= 1'b1;
    end
  end

`ifdef FETCH_FAULT_EN
  // The fault flag survives consumption so the halt stays visible until a redirect.
  logic r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_fault <= 1'b0;
    else if (i_flush) r_fault <= 1'b0;
    else if (i_load)  r_fault <= i_load_fault;
  end

  assign o_fault = r_fault;
`endif

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Single-slot instruction fetch unit with redirect/drop handling.
// FETCH_FAULT_EN enables imem_err reporting and the HALT state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e r_state, w_state_next;
  logic [63:0]  r_fetch_pc, w_fetch_pc_next;
  logic [63:0]  r_drop_addr, w_drop_addr_next;
  logic         w_slot_valid;
  logic         w_consume;
  logic         w_req;
  logic [63:0]  w_addr;
  logic         w_load;
  logic         w_load_err;
  logic [31:0]  w_load_instr;

  assign w_consume = w_slot_valid & ~bus.hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_fetch_pc  <= w_fetch_pc_next;
      r_drop_addr <= w_drop_addr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_fetch_pc_next  = r_fetch_pc;
    w_drop_addr_next = r_drop_addr;
    w_req            = 1'b0;
    w_addr           = '0;
    w_load           = 1'b0;
    w_load_err       = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        w_req  = ~w_slot_valid | w_consume;
        w_addr = r_fetch_pc;
        if (bus.redirect) begin
          // An unanswered request must stay on the bus until its ack arrives.
          if (w_req && !bus.imem_ack) begin
            w_state_next     = ST_DROP;
            w_drop_addr_next = r_fetch_pc;
          end
        end else if (w_req && bus.imem_ack) begin
          w_load = 1'b1;
`ifdef FETCH_FAULT_EN
          if (bus.imem_err) begin
            w_load_err   = 1'b1;
            w_state_next = ST_HALT;
          end
`endif
          if (!w_load_err) w_fetch_pc_next = r_fetch_pc + PC_INCR;
        end
      end
      ST_DROP: begin
        w_req  = 1'b1;
        w_addr = r_drop_addr;
        if (bus.imem_ack) w_state_next = ST_FETCH;
      end
`ifdef FETCH_FAULT_EN
      ST_HALT: begin
        w_addr = r_fetch_pc;
        if (bus.redirect) w_state_next = ST_FETCH;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
    if (bus.redirect) w_fetch_pc_next = align_pc(bus.redirect_pc);
  end

  assign w_load_instr = w_load_err ? NOP_INSTR : bus.imem_rdata;

  fetch_slot u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_flush      (bus.redirect),
    .i_consume    (w_consume),
    .i_load_pc    (r_fetch_pc),
    .i_load_instr (w_load_instr),
`ifdef FETCH_FAULT_EN
    .i_load_fault (w_load_err),
    .o_fault      (bus.fault),
`endif
    .o_pc         (bus.pc),
    .o_instr      (bus.instruc),
    .o_valid      (w_slot_valid)
  );

  assign bus.valid     = w_slot_valid;
  assign bus.imem_req  = w_req;
  assign bus.imem_addr = w_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC stream model, random-latency memory, directed cases.
// Define FETCH_FAULT_EN to include the fault/halt scenario.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] TB_RESET_PC = 64'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: any fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // Expected instruction stream: sequential from the last start point, restarted by redirect/reset.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        exp_q[$];
  logic [63:0] gen_pc;
  logic        err_arm = 1'b0;
  localparam logic [63:0] ERR_ADDR = 64'h40;

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc    = gen_pc;
      e.instr = (err_arm && gen_pc == ERR_ADDR) ? 32'h0 : mem_word(gen_pc);
      exp_q.push_back(e);
      gen_pc  = gen_pc + 64'd4;
    end
  endtask

  task automatic restart_stream(input logic [63:0] start);
    exp_q.delete();
    gen_pc = start & ~64'h3;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!bus.valid && k < 60) begin
      tick();
      k++;
    end
    chk(name, 64'(bus.valid), 64'd1);
  endtask

  // Memory responder: 0 = zero wait, 1 = random wait, 2 = fixed 3-cycle wait.
  int          mem_mode = 0;
  logic        pending  = 1'b0;
  int          wcnt     = 0;
  logic [63:0] held_addr;

  always @(negedge clk) begin
    if (rst_n && bus.imem_req) begin
      if (pending) begin
        chk("addr_stable", bus.imem_addr, held_addr);
      end else begin
        pending   = 1'b1;
        held_addr = bus.imem_addr;
        if (mem_mode == 0)      wcnt = 0;
        else if (mem_mode == 2) wcnt = 3;
        else                    wcnt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      if (wcnt == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
`ifdef FETCH_FAULT_EN
        bus.imem_err   = err_arm && (bus.imem_addr == ERR_ADDR);
`endif
        pending = 1'b0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
`ifdef FETCH_FAULT_EN
        bus.imem_err   = 1'b0;
`endif
        wcnt--;
      end
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
`ifdef FETCH_FAULT_EN
      bus.imem_err   = 1'b0;
`endif
      pending = 1'b0;
    end
  end

  // Monitor: pops the expected stream on every consumed slot, checks bubbles and hazard holds.
  logic        prev_hold = 1'b0;
  logic [63:0] prev_pc;
  logic [31:0] prev_instr;
  int          n_consumed = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (!bus.valid) begin
        chk("bubble_pc", bus.pc, 64'd0);
        chk("bubble_instr", 64'(bus.instruc), 64'd0);
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(bus.valid), 64'd1);
        chk("hold_pc", bus.pc, prev_pc);
        chk("hold_instr", 64'(bus.instruc), 64'(prev_instr));
      end
      if (bus.valid && bus.hazard) chk("req_in_hazard", 64'(bus.imem_req), 64'd0);
      if (bus.valid && !bus.hazard && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got pc %h with no expected entry", bus.pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", bus.pc, e.pc);
          chk("sb_instr", 64'(bus.instruc), 64'(e.instr));
          n_consumed++;
        end
      end
      prev_hold  = bus.valid && bus.hazard && !bus.redirect;
      prev_pc    = bus.pc;
      prev_instr = bus.instruc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] old_addr;
    logic [63:0] rp;
    int k;
    bus.hazard      = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    restart_stream(TB_RESET_PC);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_addr", bus.imem_addr, 64'd0);
    chk("rst_pc", bus.pc, 64'd0);
    chk("rst_instr", 64'(bus.instruc), 64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
`ifdef FETCH_FAULT_EN
    chk("rst_fault", 64'(bus.fault), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-wait startup: first request after IDLE, then one instruction per cycle
    tick();
    chk("start_req", 64'(bus.imem_req), 64'd1);
    chk("start_addr", bus.imem_addr, TB_RESET_PC);
    chk("start_valid", 64'(bus.valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_valid", 64'(bus.valid), 64'd1);
      chk("seq_pc", bus.pc, TB_RESET_PC + 64'(4 * i));
    end

    // Hazard for three cycles while the slot holds pc=8
    bus.hazard = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hz_req", 64'(bus.imem_req), 64'd0);
      chk("hz_pc", bus.pc, 64'h8);
      chk("hz_instr", 64'(bus.instruc), 64'(mem_word(64'h8)));
      tick();
    end
    bus.hazard = 1'b0;
    chk("hz_last_pc", bus.pc, 64'h8);
    tick();
    chk("hz_resume_pc", bus.pc, 64'hC);

    // Redirect to 0x100 while the ack is delayed 3 cycles
    mem_mode = 2;
    old_addr = bus.imem_addr;
    chk("pre_redir_req", 64'(bus.imem_req), 64'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h100;
    restart_stream(64'h100);
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_req", 64'(bus.imem_req), 64'd1);
      chk("drop_addr", bus.imem_addr, old_addr);
      chk("drop_valid", 64'(bus.valid), 64'd0);
      tick();
    end
    chk("post_drop_req", 64'(bus.imem_req), 64'd1);
    chk("post_drop_addr", bus.imem_addr, 64'h100);
    mem_mode = 0;
    wait_valid("redir_valid_timeout");
    chk("redir_first_pc", bus.pc, 64'h100);
    chk("redir_first_instr", 64'(bus.instruc), 64'(mem_word(64'h100)));

    // Unaligned redirect in the same cycle as a zero-wait ack
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h203;
    restart_stream(64'h200);
    tick();
    bus.redirect = 1'b0;
    chk("ackredir_valid", 64'(bus.valid), 64'd0);
    chk("ackredir_req", 64'(bus.imem_req), 64'd1);
    chk("ackredir_addr", bus.imem_addr, 64'h200);
    tick();
    chk("ackredir_pc", bus.pc, 64'h200);

    // Asynchronous reset in the middle of a delayed request
    mem_mode = 2;
    k = 0;
    while (!bus.imem_req && k < 20) begin
      tick();
      k++;
    end
    chk("midrst_req_seen", 64'(bus.imem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 64'(bus.imem_req), 64'd0);
    chk("midrst_addr", bus.imem_addr, 64'd0);
    chk("midrst_pc", bus.pc, 64'd0);
    chk("midrst_instr", 64'(bus.instruc), 64'd0);
    chk("midrst_valid", 64'(bus.valid), 64'd0);
`ifdef FETCH_FAULT_EN
    err_arm = 1'b1;
`endif
    restart_stream(TB_RESET_PC);
    mem_mode = 0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_valid("restart_valid_timeout");
    chk("restart_pc", bus.pc, TB_RESET_PC);

`ifdef FETCH_FAULT_EN
    // Error on the fetch at 0x40, halt, then recover via redirect to 0x80
    k = 0;
    while (!bus.fault && k < 60) begin
      tick();
      k++;
    end
    chk("fault_set", 64'(bus.fault), 64'd1);
    chk("fault_pc", bus.pc, ERR_ADDR);
    chk("fault_instr", 64'(bus.instruc), 64'd0);
    chk("fault_valid", 64'(bus.valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_req", 64'(bus.imem_req), 64'd0);
      chk("halt_fault", 64'(bus.fault), 64'd1);
    end
    err_arm         = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h80;
    restart_stream(64'h80);
    tick();
    bus.redirect = 1'b0;
    chk("unhalt_fault", 64'(bus.fault), 64'd0);
    chk("unhalt_addr", bus.imem_addr, 64'h80);
    wait_valid("unhalt_valid_timeout");
    chk("unhalt_pc", bus.pc, 64'h80);
`endif

    // Randomized hazards, redirects and memory latency against the stream model
    mem_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      bus.hazard = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 2))
          0:       rp = 64'($urandom_range(0, 4095));
          1:       rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
          default: rp = {$urandom, $urandom};
        endcase
        bus.redirect    = 1'b1;
        bus.redirect_pc = rp;
        restart_stream(rp);
      end else begin
        bus.redirect = 1'b0;
      end
      tick();
    end
    bus.hazard   = 1'b0;
    bus.redirect = 1'b0;
    repeat (20) tick();
    chk("progress", 64'(n_consumed > 1000), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 hazard  in  1  decode-side stall; the fetch slot is not consumed while high.
REQ-005 redirect  in  1  flush request for a taken branch or jump.
REQ-006 redirect_pc  in  64  new fetch address; bits [1:0] SHALL be forced to 0.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  64  request address; stable while imem_req is high and imem_ack is low.
REQ-009 imem_ack  in  1  completion; may arrive in the same cycle as imem_req or any later cycle.
REQ-010 imem_rdata  in  32  instruction word; valid only when imem_ack is high.
REQ-011 pc  out  64  slot PC, driven to the decode-stage input register.
REQ-012 instruc  out  32  slot instruction; 32'b0 (bubble) when the slot is empty.
REQ-013 valid  out  1  slot holds a live instruction.

Function
REQ-014 FSM states: IDLE, FETCH, DROP (plus HALT when FETCH_FAULT_EN is defined).
REQ-015 IDLE: entered only from reset; moves to FETCH one cycle after rst_n deasserts; imem_req is 0.
REQ-016 FETCH: imem_req=1 and imem_addr=fetch_pc whenever the slot is empty or is consumed this cycle; otherwise imem_req=0.
REQ-017 Consume: the slot is consumed on a cycle with valid=1 and hazard=0.
REQ-018 On imem_ack in FETCH with no redirect: slot loads {fetch_pc, imem_rdata}, valid=1, fetch_pc+=4 (64-bit wrap). Effective latency is 1 cycle from ack to output.
REQ-019 Steady-state throughput SHALL be 1 instruction per cycle when imem_ack arrives with zero wait.
REQ-020 If the slot is consumed with no ack in the same cycle, the slot clears to valid=0, pc=0, instruc=0.
REQ-021 While hazard=1, the slot and its outputs SHALL hold unchanged and no new request is issued.
REQ-022 Redirect has priority over hazard and ack: the slot clears and fetch_pc<=redirect_pc.
REQ-023 Redirect while a request is outstanding and imem_ack=0: go to DROP, holding imem_req/imem_addr at the old value.
REQ-024 DROP: discard the data on imem_ack, then return to FETCH at the redirected fetch_pc.
REQ-025 Redirect in a cycle with imem_ack=1: the data is discarded; the next cycle issues the request to redirect_pc.
REQ-026 A second redirect while in DROP updates fetch_pc and remains in DROP.

Reset
REQ-027 On rst_n=0: state=IDLE, fetch_pc=RESET_PC, pc=0, instruc=0, valid=0, imem_req=0, imem_addr=0.
REQ-028 Reset mid-request abandons the transaction; the memory side tolerates a dropped request.

Configuration
REQ-029 Macro FETCH_FAULT_EN adds input imem_err (1 bit, valid with imem_ack) and output fault (1 bit, reset 0).
REQ-030 With FETCH_FAULT_EN, on ack with imem_err: the slot loads pc=fetch_pc, instruc=0, valid=1, fault=1, and the FSM enters HALT (no requests).
REQ-031 HALT exits only on redirect, which clears fault.
REQ-032 Without FETCH_FAULT_EN: the imem_err and fault ports and the HALT state are absent, and every ack is a good instruction.

Structure
REQ-033 Shared package fetch_pkg holds the FSM state enum, the NOP/bubble encoding 32'b0, the PC increment constant 4 and the RESET_PC default.
REQ-034 One sub-module, fetch_slot, implements the output holding register (load/consume/clear).

Verification
REQ-035 Reset release with zero-wait ack, hazard=0 -> pc sequence 0,4,8,12 on consecutive cycles, valid=1 from the 2nd cycle after rst_n.
REQ-036 hazard=1 for 3 cycles while the slot holds pc=8 -> pc/instruc held for 3 cycles, imem_req=0, resume at pc=12.
REQ-037 redirect to 0x100 while ack is delayed 3 cycles -> imem_addr held at the old address until ack, data dropped, next request addr=0x100, first valid pc=0x100.
REQ-038 redirect_pc=0x203 in the same cycle as ack -> slot cleared, next imem_addr=0x200.
REQ-039 rst_n pulsed low mid-request -> all outputs are 0 immediately and fetch restarts at RESET_PC.
REQ-040 FETCH_FAULT_EN: imem_err with ack at pc=0x40 -> fault=1, instruc=0, no requests until redirect to 0x80 clears fault and fetch restarts there.
